// File: rtl/sba_preload_pkg.sv
// Shared types and constants for the SBA preload bridge: SBCS layout,
// DMI register addresses, DMI opcodes and the memory-port FSM states.
package sba_preload_pkg;

   localparam int unsigned DmiAddrSbcs    = 'h38;
   localparam int unsigned DmiAddrSbAddr0 = 'h39;
   localparam int unsigned DmiAddrSbData0 = 'h3C;

   localparam logic [2:0] SbAccess32    = 3'd2;
   localparam logic [2:0] SbErrBadSize  = 3'd4;
   localparam logic [2:0] SbErrOther    = 3'd7;

   typedef enum logic [1:0] {
      DMI_NOP   = 2'd0,
      DMI_READ  = 2'd1,
      DMI_WRITE = 2'd2
   } dmi_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } sba_state_e;

   typedef struct packed {
      logic [2:0] sbversion;
      logic [5:0] rsvd;
      logic       sbbusyerror;
      logic       sbbusy;
      logic       sbreadonaddr;
      logic [2:0] sbaccess;
      logic       sbautoincrement;
      logic       sbreadondata;
      logic [2:0] sberror;
      logic [6:0] sbasize;
      logic       sbaccess128;
      logic       sbaccess64;
      logic       sbaccess32;
      logic       sbaccess16;
      logic       sbaccess8;
   } sbcs_t;

   function automatic sbcs_t sbcs_reset(input int unsigned asize);
      sbcs_t s;
      s            = '0;
      s.sbversion  = 3'd1;
      s.sbaccess   = SbAccess32;
      s.sbasize    = 7'(asize);
      s.sbaccess32 = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/sba_preload_bridge.sv
// SBA engine: DMI-visible SBCS/SBAddress0/SBData0 registers driving a
// single-outstanding 32-bit OBI-style memory port for JTAG SRAM preload.
module sba_preload_bridge
   import sba_preload_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DmiAddrW  = 7
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 dmi_req_valid_i,
   output logic                 dmi_req_ready_o,
   input  logic [DmiAddrW-1:0]  dmi_req_addr_i,
   input  logic [1:0]           dmi_req_op_i,
   input  logic [31:0]          dmi_req_data_i,
   output logic                 dmi_resp_valid_o,
   input  logic                 dmi_resp_ready_i,
   output logic [31:0]          dmi_resp_data_o,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [31:0]          mem_wdata_o,
   output logic [3:0]           mem_be_o,
   input  logic                 mem_rvalid_i,
   input  logic [31:0]          mem_rdata_i,
   input  logic                 mem_err_i
);

   // DMI: a request is taken when valid && ready, with ready = !resp_valid;
   // the response appears one cycle later and holds until resp_ready.
   sba_state_e           state_q, state_d;
   sbcs_t                sbcs_q, sbcs_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   logic                 req_we_q, req_we_d;
   logic [AddrWidth-1:0] req_addr_q, req_addr_d;
   logic [31:0]          req_wdata_q, req_wdata_d;
   logic                 req_inc_q, req_inc_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [31:0]          resp_data_q, resp_data_d;

   logic                 busy, dmi_acc, is_rd, is_wr;
   logic                 sel_sbcs, sel_addr, sel_data;
   logic                 start, start_we;
   logic [AddrWidth-1:0] start_addr;
   logic [31:0]          start_wdata;

   assign sel_sbcs = (dmi_req_addr_i == DmiAddrW'(DmiAddrSbcs));
   assign sel_addr = (dmi_req_addr_i == DmiAddrW'(DmiAddrSbAddr0));
   assign sel_data = (dmi_req_addr_i == DmiAddrW'(DmiAddrSbData0));

   always_comb begin
      state_d      = state_q;
      sbcs_d       = sbcs_q;
      addr_d       = addr_q;
      data_d       = data_q;
      req_we_d     = req_we_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_inc_d    = req_inc_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      busy         = (state_q != IDLE);
      dmi_acc      = dmi_req_valid_i && !resp_valid_q;
      is_rd        = dmi_acc && (dmi_req_op_i == DMI_READ);
      is_wr        = dmi_acc && (dmi_req_op_i == DMI_WRITE);
      start        = 1'b0;
      start_we     = 1'b0;
      start_addr   = addr_q;
      start_wdata  = data_q;

      if (resp_valid_q && dmi_resp_ready_i) begin
         resp_valid_d = 1'b0;
      end
      if (dmi_acc) begin
         resp_valid_d = 1'b1;
         resp_data_d  = '0;
      end

      if (is_rd) begin
         if (sel_sbcs) begin
            resp_data_d = sbcs_q;
         end else if (sel_addr) begin
            resp_data_d = 32'(addr_q);
         end else if (sel_data) begin
            resp_data_d = data_q;
            start       = sbcs_q.sbreadondata;
         end
      end

      if (is_wr) begin
         if (sel_sbcs) begin
            sbcs_d.sbbusyerror     = sbcs_q.sbbusyerror & ~dmi_req_data_i[22];
            sbcs_d.sberror         = sbcs_q.sberror & ~dmi_req_data_i[14:12];
            sbcs_d.sbreadonaddr    = dmi_req_data_i[20];
            sbcs_d.sbaccess        = dmi_req_data_i[19:17];
            sbcs_d.sbautoincrement = dmi_req_data_i[16];
            sbcs_d.sbreadondata    = dmi_req_data_i[15];
         end else if (sel_addr) begin
            if (busy) begin
               sbcs_d.sbbusyerror = 1'b1;
            end else begin
               addr_d     = AddrWidth'(dmi_req_data_i);
               start_addr = AddrWidth'(dmi_req_data_i);
               start      = sbcs_q.sbreadonaddr;
            end
         end else if (sel_data) begin
            if (busy) begin
               sbcs_d.sbbusyerror = 1'b1;
            end else begin
               data_d      = dmi_req_data_i;
               start_wdata = dmi_req_data_i;
               start_we    = 1'b1;
               start       = 1'b1;
            end
         end
      end

      // Gating looks at the pre-write error flags; a sticky error silently blocks.
      if (start) begin
         if (busy) begin
            sbcs_d.sbbusyerror = 1'b1;
         end else if ((sbcs_q.sberror == 3'd0) && !sbcs_q.sbbusyerror) begin
            if (sbcs_q.sbaccess != SbAccess32) begin
               sbcs_d.sberror = SbErrBadSize;
            end else begin
               state_d     = REQ;
               req_we_d    = start_we;
               req_addr_d  = start_addr & ~AddrWidth'(3);
               req_wdata_d = start_wdata;
               req_inc_d   = sbcs_q.sbautoincrement;
            end
         end
      end

      unique case (state_q)
         REQ: begin
            if (mem_gnt_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               state_d = IDLE;
               if (mem_err_i) begin
                  sbcs_d.sberror = SbErrOther;
               end else begin
                  if (!req_we_q) begin
                     data_d = mem_rdata_i;
                  end
                  if (req_inc_q) begin
                     addr_d = addr_q + AddrWidth'(4);
                  end
               end
            end
         end
         default: begin
         end
      endcase

      sbcs_d.sbbusy = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         sbcs_q       <= sbcs_reset(AddrWidth);
         addr_q       <= '0;
         data_q       <= '0;
         req_we_q     <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_inc_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         sbcs_q       <= sbcs_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         req_we_q     <= req_we_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_inc_q    <= req_inc_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign dmi_req_ready_o  = !resp_valid_q;
   assign dmi_resp_valid_o = resp_valid_q;
   assign dmi_resp_data_o  = resp_data_q;
   assign mem_req_o        = (state_q == REQ);
   assign mem_we_o         = req_we_q;
   assign mem_addr_o       = req_addr_q;
   assign mem_wdata_o      = req_wdata_q;
   assign mem_be_o         = 4'hF;

endmodule

// File: tb/tb_sba_preload_bridge.sv
// Bench for sba_preload_bridge: transaction-level register model, memory
// responder with scripted grant/latency/error, per-cycle output compare.
module tb_sba_preload_bridge;

   logic        clk_i, rst_i;
   logic        dmi_req_valid_i, dmi_req_ready_o;
   logic [6:0]  dmi_req_addr_i;
   logic [1:0]  dmi_req_op_i;
   logic [31:0] dmi_req_data_i;
   logic        dmi_resp_valid_o, dmi_resp_ready_i;
   logic [31:0] dmi_resp_data_o;
   logic        mem_req_o, mem_gnt_i, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;

   sba_preload_bridge #(.AddrWidth(32), .DmiAddrW(7)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
      .dmi_req_addr_i(dmi_req_addr_i), .dmi_req_op_i(dmi_req_op_i),
      .dmi_req_data_i(dmi_req_data_i), .dmi_resp_valid_o(dmi_resp_valid_o),
      .dmi_resp_ready_i(dmi_resp_ready_i), .dmi_resp_data_o(dmi_resp_data_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
   );

   localparam logic [6:0] A_SBCS = 7'h38;
   localparam logic [6:0] A_ADDR = 7'h39;
   localparam logic [6:0] A_DATA = 7'h3C;

   int n_checks = 0;
   int n_errors = 0;
   int n_grants = 0;

   logic gnt_en, err_next;
   int   rv_delay, resp_delay;
   logic [31:0] mem [logic [31:0]];

   assign mem_gnt_i = mem_req_o & gnt_en;

   // ---------------- clock ----------------
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #400000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   int          m_phase;
   logic        m_be, m_roa, m_inc, m_rod, m_cur_we, m_cur_inc, m_resp_pend;
   logic [2:0]  m_access, m_err;
   logic [31:0] m_addr, m_data, m_resp_data;
   logic [64:0] exp_q[$];

   function automatic logic [31:0] m_sbcs(input logic busy);
      return (32'd1 << 29) | (32'(m_be) << 22) | (32'(busy) << 21) | (32'(m_roa) << 20)
           | (32'(m_access) << 17) | (32'(m_inc) << 16) | (32'(m_rod) << 15)
           | (32'(m_err) << 12) | (32'd32 << 5) | (32'd1 << 2);
   endfunction

   task automatic m_start(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic busy);
      if (busy) m_be = 1'b1;
      else if (m_err == 3'd0 && !m_be) begin
         if (m_access != 3'd2) m_err = 3'd4;
         else begin
            m_phase   = 1;
            m_cur_we  = we;
            m_cur_inc = m_inc;
            exp_q.push_back({we, a & 32'hFFFF_FFFC, wd});
         end
      end
   endtask

   task automatic m_step();
      logic busy, acc, do_gnt, do_cpl;
      logic [31:0] d;
      if (rst_i) begin
         m_phase = 0; m_be = 0; m_roa = 0; m_inc = 0; m_rod = 0;
         m_access = 3'd2; m_err = 3'd0; m_addr = 0; m_data = 0;
         m_cur_we = 0; m_cur_inc = 0; m_resp_pend = 0; m_resp_data = 0;
         exp_q.delete();
         return;
      end
      busy   = (m_phase != 0);
      acc    = dmi_req_valid_i && !m_resp_pend;
      do_gnt = (m_phase == 1) && gnt_en;
      do_cpl = (m_phase == 2) && mem_rvalid_i;
      d      = dmi_req_data_i;
      if (m_resp_pend && dmi_resp_ready_i) m_resp_pend = 0;
      if (acc) begin
         m_resp_pend = 1;
         m_resp_data = 0;
         if (dmi_req_op_i == 2'd1) begin
            if (dmi_req_addr_i == A_SBCS) m_resp_data = m_sbcs(busy);
            else if (dmi_req_addr_i == A_ADDR) m_resp_data = m_addr;
            else if (dmi_req_addr_i == A_DATA) begin
               m_resp_data = m_data;
               if (m_rod) m_start(1'b0, m_addr, 32'd0, busy);
            end
         end else if (dmi_req_op_i == 2'd2) begin
            if (dmi_req_addr_i == A_SBCS) begin
               if (d[22]) m_be = 0;
               m_err    = m_err & ~d[14:12];
               m_roa    = d[20];
               m_access = d[19:17];
               m_inc    = d[16];
               m_rod    = d[15];
            end else if (dmi_req_addr_i == A_ADDR) begin
               if (busy) m_be = 1;
               else begin
                  m_addr = d;
                  if (m_roa) m_start(1'b0, d, 32'd0, 1'b0);
               end
            end else if (dmi_req_addr_i == A_DATA) begin
               if (busy) m_be = 1;
               else begin
                  m_data = d;
                  m_start(1'b1, m_addr, d, 1'b0);
               end
            end
         end
      end
      if (do_gnt) begin
         m_phase = 2;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (do_cpl) begin
         m_phase = 0;
         if (mem_err_i) m_err = 3'd7;
         else begin
            if (!m_cur_we) m_data = mem_rdata_i;
            if (m_cur_inc) m_addr = m_addr + 32'd4;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_i);
         m_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [64:0] e;
      @(posedge clk_i);
      forever begin
         @(negedge clk_i);
         chk("req_ready", 32'(dmi_req_ready_o), 32'(!m_resp_pend));
         chk("resp_valid", 32'(dmi_resp_valid_o), 32'(m_resp_pend));
         if (m_resp_pend) chk("resp_data", dmi_resp_data_o, m_resp_data);
         chk("mem_req", 32'(mem_req_o), 32'(m_phase == 1));
         chk("mem_be", 32'(mem_be_o), 32'hF);
         if (mem_req_o && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("mem_we", 32'(mem_we_o), 32'(e[64]));
            chk("mem_addr", mem_addr_o, e[63:32]);
            if (e[64]) chk("mem_wdata", mem_wdata_o, e[31:0]);
         end
      end
   end

   // ---------------- memory responder ----------------
   initial begin
      logic [31:0] a, wd;
      logic        we, er;
      mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         if (mem_req_o && gnt_en && !rst_i) begin
            a = mem_addr_o; we = mem_we_o; wd = mem_wdata_o; er = err_next;
            n_grants++;
            @(posedge clk_i);
            repeat (rv_delay) @(posedge clk_i);
            #1;
            if (we && !er) mem[a] = wd;
            mem_rdata_i  = (!we && mem.exists(a)) ? mem[a] : 32'd0;
            mem_err_i    = er;
            mem_rvalid_i = 1'b1;
            @(posedge clk_i);
            #1;
            mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic dmi_xfer(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                           output logic [31:0] rd);
      int n;
      @(negedge clk_i);
      dmi_req_valid_i = 1'b1; dmi_req_addr_i = a; dmi_req_op_i = op; dmi_req_data_i = d;
      n = 0;
      while (!dmi_req_ready_o && n < 20) begin @(negedge clk_i); n++; end
      chk("req_accept_timeout", 32'(n < 20), 32'd1);
      @(posedge clk_i);
      #1;
      dmi_req_valid_i = 1'b0; dmi_req_op_i = 2'd0;
      @(negedge clk_i);
      n = 0;
      while (!dmi_resp_valid_o && n < 20) begin @(negedge clk_i); n++; end
      chk("resp_timeout", 32'(dmi_resp_valid_o), 32'd1);
      repeat (resp_delay) @(negedge clk_i);
      rd = dmi_resp_data_o;
      dmi_resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      dmi_resp_ready_i = 1'b0;
   endtask

   task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
      logic [31:0] unused;
      dmi_xfer(a, 2'd2, d, unused);
   endtask

   task automatic dmi_rd(input logic [6:0] a, output logic [31:0] v);
      dmi_xfer(a, 2'd1, 32'd0, v);
   endtask

   task automatic wait_idle();
      logic [31:0] v;
      int n;
      n = 0;
      dmi_rd(A_SBCS, v);
      while (v[21] && n < 50) begin dmi_rd(A_SBCS, v); n++; end
      chk("idle_timeout", 32'(v[21]), 32'd0);
   endtask

   task automatic at_edge();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] v;
      int g0;
      rst_i = 1'b1; dmi_req_valid_i = 1'b0; dmi_req_addr_i = '0; dmi_req_op_i = '0;
      dmi_req_data_i = '0; dmi_resp_ready_i = 1'b0;
      gnt_en = 1'b1; err_next = 1'b0; rv_delay = 0; resp_delay = 0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_resp_valid", 32'(dmi_resp_valid_o), 32'd0);

      // 1: reset SBCS value
      dmi_rd(A_SBCS, v);
      chk("t1_sbcs_reset", v, 32'h2004_0404);

      // 2: autoincrement write stream
      resp_delay = 2;
      dmi_wr(A_SBCS, 32'h0005_0000);
      dmi_wr(A_ADDR, 32'h0000_1000);
      resp_delay = 0;
      dmi_wr(A_DATA, 32'hA); wait_idle();
      dmi_wr(A_DATA, 32'hB); wait_idle();
      dmi_wr(A_DATA, 32'hC); wait_idle();
      chk("t2_mem_1000", mem[32'h1000], 32'hA);
      chk("t2_mem_1004", mem[32'h1004], 32'hB);
      chk("t2_mem_1008", mem[32'h1008], 32'hC);
      dmi_rd(A_ADDR, v);
      chk("t2_addr_after", v, 32'h0000_100C);

      // 3: read on address, then read on data
      mem[32'h2000] = 32'hDEAD_BEEF;
      mem[32'h2004] = 32'h1111_2222;
      mem[32'h2008] = 32'h3333_4444;
      dmi_wr(A_SBCS, 32'h0015_0000);
      dmi_wr(A_ADDR, 32'h0000_2000);
      wait_idle();
      dmi_rd(A_DATA, v);
      chk("t3_roa_data", v, 32'hDEAD_BEEF);
      dmi_wr(A_SBCS, 32'h0005_8000);
      dmi_rd(A_DATA, v); wait_idle();
      chk("t3_rod_first", v, 32'hDEAD_BEEF);
      dmi_rd(A_DATA, v); wait_idle();
      chk("t3_rod_2004", v, 32'h1111_2222);
      dmi_rd(A_DATA, v); wait_idle();
      chk("t3_rod_2008", v, 32'h3333_4444);
      dmi_wr(A_SBCS, 32'h0005_0000);
      dmi_rd(A_ADDR, v);
      chk("t3_addr_after", v, 32'h0000_2010);

      // 4: stalled grant, busy error, W1C
      at_edge(); gnt_en = 1'b0;
      g0 = n_grants;
      dmi_wr(A_DATA, 32'h55);
      repeat (20) @(negedge clk_i);
      chk("t4_req_held", 32'(mem_req_o), 32'd1);
      dmi_wr(A_DATA, 32'h66);
      dmi_rd(A_SBCS, v);
      chk("t4_busyerr_set", 32'(v[22]), 32'd1);
      chk("t4_busy_set", 32'(v[21]), 32'd1);
      at_edge(); gnt_en = 1'b1;
      wait_idle();
      chk("t4_one_grant", 32'(n_grants - g0), 32'd1);
      chk("t4_mem_2010", mem[32'h2010], 32'h55);
      dmi_rd(A_DATA, v);
      chk("t4_data_kept", v, 32'h55);
      dmi_wr(A_SBCS, 32'h0045_0000);
      dmi_rd(A_SBCS, v);
      chk("t4_busyerr_clr", v, 32'h2005_0404);

      // 5: bus error
      at_edge(); err_next = 1'b1;
      dmi_wr(A_DATA, 32'h77);
      wait_idle();
      at_edge(); err_next = 1'b0;
      dmi_rd(A_SBCS, v);
      chk("t5_sberror7", v, 32'h2005_7404);
      dmi_rd(A_ADDR, v);
      chk("t5_addr_kept", v, 32'h0000_2014);
      g0 = n_grants;
      dmi_wr(A_DATA, 32'h88);
      repeat (5) @(negedge clk_i);
      chk("t5_blocked", 32'(n_grants - g0), 32'd0);
      dmi_wr(A_SBCS, 32'h0005_7000);
      dmi_rd(A_SBCS, v);
      chk("t5_err_clr", v, 32'h2005_0404);
      dmi_wr(A_DATA, 32'h99);
      wait_idle();
      chk("t5_mem_2014", mem[32'h2014], 32'h99);

      // 6: bad size, then reset in REQ and in WAIT
      dmi_wr(A_SBCS, 32'h0001_0000);
      g0 = n_grants;
      dmi_wr(A_DATA, 32'h1);
      dmi_rd(A_SBCS, v);
      chk("t6_badsize", v, 32'h2001_4404);
      chk("t6_no_grant", 32'(n_grants - g0), 32'd0);
      dmi_wr(A_SBCS, 32'h0005_7000);
      at_edge(); gnt_en = 1'b0;
      dmi_wr(A_DATA, 32'hAB);
      chk("t6_in_req", 32'(mem_req_o), 32'd1);
      at_edge(); rst_i = 1'b1;
      at_edge();
      chk("t6_req_drop", 32'(mem_req_o), 32'd0);
      rst_i = 1'b0; gnt_en = 1'b1;
      dmi_rd(A_SBCS, v);
      chk("t6_sbcs_rst", v, 32'h2004_0404);
      dmi_rd(A_ADDR, v);
      chk("t6_addr_rst", v, 32'd0);
      dmi_rd(A_DATA, v);
      chk("t6_data_rst", v, 32'd0);

      mem[32'h0] = 32'h5555_AAAA;
      rv_delay = 3;
      dmi_wr(A_SBCS, 32'h0014_0000);
      dmi_wr(A_ADDR, 32'h0);
      rst_i = 1'b1;
      at_edge(); rst_i = 1'b0;
      repeat (8) @(posedge clk_i);
      #1; rv_delay = 0;
      dmi_rd(A_DATA, v);
      chk("t6_rvalid_dropped", v, 32'd0);
      dmi_rd(A_SBCS, v);
      chk("t6_sbcs_after", v, 32'h2004_0404);

      repeat (3) @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
